// File: rtl/cache_controller_if.sv
// Signal bundle between the cache sequencing controller and the CPU port,
// the tag/data array and main memory.
interface cache_controller_if #(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 26,
  parameter int CNT_WIDTH   = 16
);
  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + 2;

  // iReq is held with iAddress stable until the single-cycle oDone; a new request may
  // start the cycle after oDone. oMemRead stays high up to and including the iMemValid cycle.
  logic                   iReq;
  logic [ADDR_WIDTH-1:0]  iAddress;
  logic                   iHit;
  logic                   iFlush;
  logic [ADDR_WIDTH-1:0]  iFlushAddress;
  logic                   iFlushAll;
  logic                   iMemValid;
  logic                   oMemRead;
  logic [ADDR_WIDTH-1:0]  oMemAddress;
  logic                   oFill;
  logic [INDEX_WIDTH-1:0] oFillIndex;
  logic [TAG_WIDTH-1:0]   oFillTag;
  logic                   oFillValid;
  logic                   oStall;
  logic                   oDone;
  logic [CNT_WIDTH-1:0]   oHitCount;
  logic [CNT_WIDTH-1:0]   oMissCount;
  logic [1:0]             oState;

  modport master (
    output iReq, iAddress, iHit, iFlush, iFlushAddress, iFlushAll, iMemValid,
    input  oMemRead, oMemAddress, oFill, oFillIndex, oFillTag, oFillValid,
           oStall, oDone, oHitCount, oMissCount, oState
  );

  modport slave (
    input  iReq, iAddress, iHit, iFlush, iFlushAddress, iFlushAll, iMemValid,
    output oMemRead, oMemAddress, oFill, oFillIndex, oFillTag, oFillValid,
           oStall, oDone, oHitCount, oMissCount, oState
  );
endinterface

// File: rtl/cache_controller.sv
// Miss/refill/flush sequencer for a 16-line direct-mapped cache. Array strobes, oStall and
// oDone are decoded from state and this cycle's inputs; memory request and counters are flops.
module cache_controller #(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 26,
  parameter int CNT_WIDTH   = 16
) (
  input  logic              iClk,
  input  logic              iRst,
  cache_controller_if.slave bus
);
  localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + 2;
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [CNT_WIDTH-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {
    FLUSH_ALL = 2'd0,
    IDLE      = 2'd1,
    MISS      = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] flush_cnt;
  logic [INDEX_WIDTH-1:0] pend_index;
  logic                   pend_single;
  logic                   pend_all;
  logic                   mem_read;
  logic [ADDR_WIDTH-1:0]  mem_address;
  logic [CNT_WIDTH-1:0]   hit_count;
  logic [CNT_WIDTH-1:0]   miss_count;

  logic [INDEX_WIDTH-1:0] new_flush_index;
  logic [INDEX_WIDTH-1:0] refill_index;
  logic [TAG_WIDTH-1:0]   refill_tag;
  logic                   in_idle;
  logic                   do_flush_all;
  logic                   do_flush_one;
  logic                   do_hit;
  logic                   do_miss;
  logic                   unused_addr_bits;

  assign new_flush_index  = bus.iFlushAddress[INDEX_WIDTH+1:2];
  assign refill_index     = mem_address[INDEX_WIDTH+1:2];
  assign refill_tag       = mem_address[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign unused_addr_bits = ^{bus.iAddress[1:0], bus.iFlushAddress[1:0],
                              bus.iFlushAddress[ADDR_WIDTH-1:INDEX_WIDTH+2]};

  // IDLE arbitration: flush work always beats the CPU, a whole-cache flush beats a single line.
  always_comb begin
    in_idle      = (state == IDLE);
    do_flush_all = in_idle && (pend_all || bus.iFlushAll);
    do_flush_one = in_idle && !do_flush_all && (pend_single || bus.iFlush);
    do_hit       = in_idle && !do_flush_all && !do_flush_one && bus.iReq && bus.iHit;
    do_miss      = in_idle && !do_flush_all && !do_flush_one && bus.iReq && !bus.iHit;
  end

  always_comb begin
    bus.oFill      = 1'b0;
    bus.oFillIndex = '0;
    bus.oFillTag   = '0;
    bus.oFillValid = 1'b0;
    bus.oStall     = 1'b0;
    bus.oDone      = 1'b0;
    if (!iRst) begin
      case (state)
        FLUSH_ALL: begin
          bus.oFill      = 1'b1;
          bus.oFillIndex = flush_cnt;
          bus.oStall     = 1'b1;
        end
        IDLE: begin
          if (do_flush_all) begin
            bus.oStall = bus.iReq;
          end else if (do_flush_one) begin
            bus.oFill      = 1'b1;
            bus.oFillIndex = pend_single ? pend_index : new_flush_index;
            bus.oStall     = bus.iReq;
          end else if (do_hit) begin
            bus.oDone = 1'b1;
          end else if (do_miss) begin
            bus.oStall = 1'b1;
          end
        end
        MISS: begin
          bus.oStall = 1'b1;
          // The array captures the memory word on this same edge.
          if (bus.iMemValid) begin
            bus.oFill      = 1'b1;
            bus.oFillValid = 1'b1;
            bus.oFillIndex = refill_index;
            bus.oFillTag   = refill_tag;
          end
        end
        RESP: begin
          bus.oDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.oMemRead    = mem_read;
  assign bus.oMemAddress = mem_address;
  assign bus.oHitCount   = hit_count;
  assign bus.oMissCount  = miss_count;
  assign bus.oState      = state;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= FLUSH_ALL;
      flush_cnt   <= '0;
      pend_index  <= '0;
      pend_single <= 1'b0;
      pend_all    <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
    end else begin
      // Flush requests arriving while busy are parked; two singles collapse into a full flush.
      if (!in_idle) begin
        if (bus.iFlush) begin
          if (pend_single) begin
            pend_all <= 1'b1;
          end else begin
            pend_single <= 1'b1;
            pend_index  <= new_flush_index;
          end
        end
        if (bus.iFlushAll && state != FLUSH_ALL) pend_all <= 1'b1;
      end

      case (state)
        FLUSH_ALL: begin
          if (bus.iFlushAll) begin
            flush_cnt <= '0;
          end else if (flush_cnt == LAST_INDEX) begin
            flush_cnt <= '0;
            state     <= IDLE;
          end else begin
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (do_flush_all) begin
            state       <= FLUSH_ALL;
            flush_cnt   <= '0;
            pend_all    <= 1'b0;
            pend_single <= 1'b0;
          end else if (do_flush_one) begin
            if (pend_single && bus.iFlush) pend_index <= new_flush_index;
            else if (pend_single)          pend_single <= 1'b0;
          end else if (do_hit) begin
            if (hit_count != CNT_MAX) hit_count <= hit_count + 1'b1;
          end else if (do_miss) begin
            if (miss_count != CNT_MAX) miss_count <= miss_count + 1'b1;
            mem_address <= {bus.iAddress[ADDR_WIDTH-1:2], 2'b00};
            mem_read    <= 1'b1;
            state       <= MISS;
          end
        end
        MISS: begin
          if (bus.iMemValid) begin
            mem_read <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= FLUSH_ALL;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: directed vector table, hand-written corner sequences,
// random traffic against a queue-based reference model, and counter saturation.
module tb_cache_controller;
  localparam int IW = 4;
  localparam int TW = 26;
  localparam int CW = 16;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cache_controller_if #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) bus ();

  cache_controller #(.INDEX_WIDTH(IW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        hit;
    logic        flush;
    logic [31:0] faddr;
    logic        flush_all;
    logic        mem_valid;
  } stim_t;

  typedef struct packed {
    logic        fill;
    logic [3:0]  idx;
    logic [25:0] tag;
    logic        valid;
    logic        stall;
    logic        done;
    logic        mr;
    logic [31:0] ma;
    logic [15:0] hits;
    logic [15:0] misses;
  } obs_t;

  typedef struct packed {
    stim_t s;
    obs_t  e;
  } vec_t;

  localparam int OBS_W = $bits(obs_t);

  vec_t             tbl[40];
  logic [OBS_W-1:0] exp_q[$];

  function automatic stim_t st(input logic req, input logic [31:0] addr, input logic hit,
                               input logic flush, input logic [31:0] faddr,
                               input logic flush_all, input logic mem_valid);
    stim_t s;
    s.req = req; s.addr = addr; s.hit = hit; s.flush = flush;
    s.faddr = faddr; s.flush_all = flush_all; s.mem_valid = mem_valid;
    return s;
  endfunction

  function automatic obs_t mk(input logic fill, input logic [3:0] idx, input logic [25:0] tag,
                              input logic valid, input logic stall, input logic done,
                              input logic mr, input logic [31:0] ma,
                              input logic [15:0] hits, input logic [15:0] misses);
    obs_t o;
    o.fill = fill; o.idx = idx; o.tag = tag; o.valid = valid; o.stall = stall;
    o.done = done; o.mr = mr; o.ma = ma; o.hits = hits; o.misses = misses;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.fill = bus.oFill; o.idx = bus.oFillIndex; o.tag = bus.oFillTag;
    o.valid = bus.oFillValid; o.stall = bus.oStall; o.done = bus.oDone;
    o.mr = bus.oMemRead; o.ma = bus.oMemAddress;
    o.hits = bus.oHitCount; o.misses = bus.oMissCount;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("fill=%b idx=%0d tag=%h v=%b stall=%b done=%b mr=%b ma=%h hits=%0d misses=%0d",
                     o.fill, o.idx, o.tag, o.valid, o.stall, o.done, o.mr, o.ma, o.hits, o.misses);
  endfunction

  // ---------------- clock/reset and driver tasks ----------------
  task automatic drive(input stim_t s);
    bus.iReq = s.req; bus.iAddress = s.addr; bus.iHit = s.hit;
    bus.iFlush = s.flush; bus.iFlushAddress = s.faddr;
    bus.iFlushAll = s.flush_all; bus.iMemValid = s.mem_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    #3;
    act = sample();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the cache by what it is doing: a sweep position, an outstanding refill, a
  // response owed, and a queue of parked line invalidates.
  int          m_pos;
  bit          m_wait;
  bit          m_resp;
  bit          m_pall;
  bit          m_mr;
  logic [31:0] m_line;
  logic [3:0]  m_pq[$];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic model_step(input logic r, input stim_t s, output obs_t e);
    logic [3:0] fidx;
    fidx = s.faddr[5:2];
    e = '0;
    e.mr = m_mr; e.ma = m_line; e.hits = 16'(m_hits); e.misses = 16'(m_misses);
    if (r) begin
      m_pos = 0; m_wait = 0; m_resp = 0; m_pall = 0; m_pq.delete();
      m_mr = 0; m_line = '0; m_hits = 0; m_misses = 0;
    end else if (m_pos >= 0 || m_wait || m_resp) begin
      if (s.flush) begin
        if (m_pq.size() > 0) m_pall = 1;
        else m_pq.push_back(fidx);
      end
      if (s.flush_all && m_pos < 0) m_pall = 1;
      if (m_pos >= 0) begin
        e.fill = 1; e.idx = 4'(m_pos); e.stall = 1;
        m_pos = s.flush_all ? 0 : ((m_pos == 15) ? -1 : m_pos + 1);
      end else if (m_wait) begin
        e.stall = 1;
        if (s.mem_valid) begin
          e.fill = 1; e.valid = 1; e.idx = m_line[5:2]; e.tag = m_line[31:6];
          m_wait = 0; m_resp = 1; m_mr = 0;
        end
      end else begin
        e.done = 1; m_resp = 0;
      end
    end else if (m_pall || s.flush_all) begin
      e.stall = s.req; m_pos = 0; m_pall = 0; m_pq.delete();
    end else if (m_pq.size() > 0 || s.flush) begin
      e.fill = 1; e.stall = s.req;
      if (m_pq.size() > 0) begin
        e.idx = m_pq.pop_front();
        if (s.flush) m_pq.push_back(fidx);
      end else begin
        e.idx = fidx;
      end
    end else if (s.req && s.hit) begin
      e.done = 1;
      if (m_hits < 65535) m_hits++;
    end else if (s.req) begin
      e.stall = 1;
      if (m_misses < 65535) m_misses++;
      m_line = {s.addr[31:2], 2'b00}; m_mr = 1; m_wait = 1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = '0;
    a[7:6] = 2'($urandom_range(0, 3));
    a[3:2] = 2'($urandom_range(0, 3));
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    stim_t       idle_s;
    stim_t       s;
    obs_t        e;
    logic        r;
    bit          req_on;
    logic [31:0] cur_addr;

    idle_s = '0;
    rst = 1'b1;
    drive(idle_s);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Post-reset sweep: 16 invalidates, then IDLE with zero counters.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("reset_sweep[%0d]", i), mk(H, 4'(i), '0, L, H, L, L, Z, 16'd0, 16'd0));
      step();
    end
    check("idle_after_sweep", mk(L, 4'd0, '0, L, L, L, L, Z, 16'd0, 16'd0));
    step();

    // Directed vectors starting in IDLE.
    tbl[0]  = '{st(H, 32'h40, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, H, L, L, Z,     16'd0, 16'd0)};
    tbl[1]  = '{st(H, 32'h40, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, H, L, H, 32'h40, 16'd0, 16'd1)};
    tbl[2]  = tbl[1];
    tbl[3]  = tbl[1];
    tbl[4]  = '{st(H, 32'h40, L, L, Z, L, H),     mk(H, 4'd0, 26'h1, H, H, L, H, 32'h40, 16'd0, 16'd1)};
    tbl[5]  = '{st(H, 32'h40, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, H, L, 32'h40, 16'd0, 16'd1)};
    tbl[6]  = '{st(H, 32'h40, H, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, H, L, 32'h40, 16'd0, 16'd1)};
    tbl[7]  = '{st(L, Z,      L, L, Z, L, H),     mk(L, 4'd0, 26'h0, L, L, L, L, 32'h40, 16'd1, 16'd1)};
    tbl[8]  = '{st(H, 32'h40, H, H, 32'h44, L, L), mk(H, 4'd1, 26'h0, L, H, L, L, 32'h40, 16'd1, 16'd1)};
    tbl[9]  = '{st(H, 32'h40, H, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, H, L, 32'h40, 16'd1, 16'd1)};
    tbl[10] = '{st(L, Z,      L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, L, L, 32'h40, 16'd2, 16'd1)};
    tbl[11] = '{st(H, 32'h80, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, H, L, L, 32'h40, 16'd2, 16'd1)};
    tbl[12] = '{st(H, 32'h80, L, H, 32'h44, L, L), mk(L, 4'd0, 26'h0, L, H, L, H, 32'h80, 16'd2, 16'd2)};
    tbl[13] = '{st(H, 32'h80, L, H, 32'h48, L, L), mk(L, 4'd0, 26'h0, L, H, L, H, 32'h80, 16'd2, 16'd2)};
    tbl[14] = '{st(H, 32'h80, L, L, Z, L, H),     mk(H, 4'd0, 26'h2, H, H, L, H, 32'h80, 16'd2, 16'd2)};
    tbl[15] = '{st(H, 32'h80, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, H, L, 32'h80, 16'd2, 16'd2)};
    tbl[16] = '{st(L, Z,      L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, L, L, 32'h80, 16'd2, 16'd2)};
    for (int i = 0; i < 16; i++)
      tbl[17+i] = '{idle_s, mk(H, 4'(i), 26'h0, L, H, L, L, 32'h80, 16'd2, 16'd2)};
    tbl[33] = '{idle_s,                           mk(L, 4'd0, 26'h0, L, L, L, L, 32'h80, 16'd2, 16'd2)};
    tbl[34] = '{st(H, 32'hC4, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, H, L, L, 32'h80, 16'd2, 16'd2)};
    tbl[35] = '{st(H, 32'hC4, L, H, 32'h44, L, L), mk(L, 4'd0, 26'h0, L, H, L, H, 32'hC4, 16'd2, 16'd3)};
    tbl[36] = '{st(H, 32'hC4, L, L, Z, L, H),     mk(H, 4'd1, 26'h3, H, H, L, H, 32'hC4, 16'd2, 16'd3)};
    tbl[37] = '{st(H, 32'hC4, L, L, Z, L, L),     mk(L, 4'd0, 26'h0, L, L, H, L, 32'hC4, 16'd2, 16'd3)};
    tbl[38] = '{idle_s,                           mk(H, 4'd1, 26'h0, L, L, L, L, 32'hC4, 16'd2, 16'd3)};
    tbl[39] = '{idle_s,                           mk(L, 4'd0, 26'h0, L, L, L, L, 32'hC4, 16'd2, 16'd3)};
    for (int i = 0; i < 40; i++) begin
      drive(tbl[i].s);
      check($sformatf("vec[%0d]", i), tbl[i].e);
      step();
    end

    // Reset while a refill is outstanding.
    s = st(H, 32'h100, L, L, Z, L, L);
    drive(s);
    check("miss_before_reset", mk(L, 4'd0, 26'h0, L, H, L, L, 32'hC4, 16'd2, 16'd3));
    step();
    check("miss_waiting", mk(L, 4'd0, 26'h0, L, H, L, H, 32'h100, 16'd2, 16'd4));
    step();
    rst = 1'b1;
    check("in_reset_cycle", mk(L, 4'd0, 26'h0, L, L, L, H, 32'h100, 16'd2, 16'd4));
    step();
    rst = 1'b0;
    drive(idle_s);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("resweep[%0d]", i), mk(H, 4'(i), '0, L, H, L, L, Z, 16'd0, 16'd0));
      step();
    end
    // Invalidate-all during the sweep restarts it from line 0.
    drive(st(L, Z, L, L, Z, H, L));
    check("restart_cycle", mk(H, 4'd5, '0, L, H, L, L, Z, 16'd0, 16'd0));
    step();
    drive(idle_s);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("restarted_sweep[%0d]", i), mk(H, 4'(i), '0, L, H, L, L, Z, 16'd0, 16'd0));
      step();
    end
    check("idle_after_restart", mk(L, 4'd0, '0, L, L, L, L, Z, 16'd0, 16'd0));
    step();

    // Random traffic against the model, starting from a fresh reset.
    rst = 1'b1;
    drive(idle_s);
    model_step(1'b1, idle_s, e);
    step();
    rst = 1'b0;
    req_on = 0;
    cur_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!req_on && $urandom_range(0, 1) == 1) begin
        req_on = 1;
        cur_addr = rand_addr();
      end
      s.req       = req_on;
      s.addr      = cur_addr;
      s.hit       = 1'($urandom_range(0, 1));
      s.flush     = ($urandom_range(0, 99) < 4);
      s.faddr     = rand_addr();
      s.flush_all = ($urandom_range(0, 199) == 0);
      s.mem_valid = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 299) == 0);
      rst = r;
      drive(s);
      model_step(r, s, e);
      exp_q.push_back(e);
      check($sformatf("random[%0d]", c), obs_t'(exp_q.pop_front()));
      if (!r && e.done) req_on = 0;
      step();
    end
    rst = 1'b0;

    // Hit counter saturation.
    rst = 1'b1;
    drive(idle_s);
    step();
    rst = 1'b0;
    repeat (16) step();
    s = st(H, 32'h40, H, L, Z, L, L);
    drive(s);
    repeat (65540) step();
    drive(idle_s);
    check("hit_saturated", mk(L, 4'd0, '0, L, L, L, L, Z, 16'hFFFF, 16'd0));
    step();
    drive(s);
    check("hit_at_max", mk(L, 4'd0, '0, L, L, H, L, Z, 16'hFFFF, 16'd0));
    step();
    drive(idle_s);
    check("hit_held_max", mk(L, 4'd0, '0, L, L, L, L, Z, 16'hFFFF, 16'd0));
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
